// File: rtl/riscv_defs.sv
// Shared RV32I control definitions: opcodes, controller states and the
// select encodings for the datapath multiplexers and ALU decoder.
package riscv_defs;

    // Base opcodes recognised by the controllers
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Multi-cycle controller states
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JALR_ADR,
        S_JUMP,
        S_LUI
    } state_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU decoder request
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_RFN  = 2'b10;
    localparam logic [1:0] ALUOP_IFN  = 2'b11;

    // Immediate format
    localparam logic [2:0] IMM_I      = 3'b000;
    localparam logic [2:0] IMM_S      = 3'b001;
    localparam logic [2:0] IMM_B      = 3'b010;
    localparam logic [2:0] IMM_J      = 3'b011;
    localparam logic [2:0] IMM_U      = 3'b100;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified instruction/data memory handshake between controller and memory.
interface multicycle_controller_if;

    logic mem_req;    // access request, held until mem_ready
    logic mem_write;  // write access (meaningful only with mem_req)
    logic adr_src;    // 0 = PC, 1 = alu_out register
    logic mem_ready;  // memory completes the access this cycle

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );

endinterface

// File: rtl/branch_taken.sv
// Branch condition resolver: turns funct3 and ALU flags from rs1-rs2 into a
// taken decision. Unsupported funct3 values simply resolve as not taken.
module branch_taken (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

    // Select the flag condition named by funct3
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;   // beq
            3'b001:  taken = !zero;  // bne
            3'b100:  taken = neg;    // blt
            3'b101:  taken = !neg;   // bge
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the shared-ALU, shared-memory multi-cycle RV32I
// datapath. Outputs are decoded from the registered state; the memory
// handshake and branch flags only gate enables in the states that use them.
module multicycle_controller
    import riscv_defs::*;
(
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        mem,
    input  logic [6:0]                     opc,
    input  logic [2:0]                     funct3,
    input  logic                           zero,
    input  logic                           neg,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic                           reg_write,
    output logic [1:0]                     alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [1:0]                     alu_op,
    output logic [2:0]                     imm_src,
    output logic [1:0]                     result_src,
    output logic                           illegal
);

    state_t state_q;
    state_t state_d;
    logic   taken;
    logic   opc_known;

    branch_taken u_branch_taken (
        .funct3 (funct3),
        .zero   (zero),
        .neg    (neg),
        .taken  (taken)
    );

    assign opc_known = opc inside {OP_R, OP_I, OP_JALR, OP_LW, OP_SW,
                                   OP_B, OP_LUI, OP_JAL};

    // State register; reset lands in FETCH immediately, aborting any access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JUMP;
                    OP_JALR:      state_d = S_JALR_ADR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_MEM_ADR:  state_d = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR_ADR: state_d = S_JUMP;
            S_JUMP:     state_d = S_ALU_WB;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control decode per state; everything is forced low while rst is high
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        imm_src       = IMM_I;
        result_src    = RES_ALUOUT;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // PC+4 goes straight from the ALU to PC as the fetch lands
                    mem.mem_req = 1'b1;
                    ir_write    = mem.mem_ready;
                    pc_write    = mem.mem_ready;
                    alu_src_a   = SRCA_PC;
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALU;
                end
                S_DECODE: begin
                    // Speculative branch/jump target into alu_out
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (opc == OP_JAL) ? IMM_J : IMM_B;
                    illegal   = !opc_known;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_RFN;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_IFN;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (opc == OP_LW) ? IMM_I : IMM_S;
                end
                S_MEM_RD: begin
                    mem.mem_req = 1'b1;
                    mem.adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MDR;
                end
                S_MEM_WR: begin
                    mem.mem_req   = 1'b1;
                    mem.mem_write = 1'b1;
                    mem.adr_src   = 1'b1;
                end
                S_BRANCH: begin
                    // Compare rs1-rs2; target computed in DECODE sits in alu_out
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_SUB;
                    result_src = RES_ALUOUT;
                    pc_write   = taken;
                end
                S_JALR_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                end
                S_JUMP: begin
                    // Target leaves alu_out for PC while old_pc+4 replaces it
                    pc_write   = 1'b1;
                    result_src = RES_ALUOUT;
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                end
                S_LUI: begin
                    imm_src    = IMM_U;
                    result_src = RES_IMM;
                    reg_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each scenario walks an
// instruction cycle by cycle and compares the full control word.
`timescale 1ns/1ps
module tb_multicycle_controller;

    // Control word: {mem_req, mem_write, adr_src, ir_write, pc_write,
    //                reg_write, a[1:0], b[1:0], op[1:0], imm[2:0], rs[1:0], illegal}
    localparam logic [17:0] V_RST   = 18'b000000_00_00_00_000_00_0;
    localparam logic [17:0] V_FET1  = 18'b100110_00_10_00_000_10_0;
    localparam logic [17:0] V_FET0  = 18'b100000_00_10_00_000_10_0;
    localparam logic [17:0] V_DEC   = 18'b000000_01_01_00_010_00_0;
    localparam logic [17:0] V_DECJ  = 18'b000000_01_01_00_011_00_0;
    localparam logic [17:0] V_DECX  = 18'b000000_01_01_00_010_00_1;
    localparam logic [17:0] V_EXR   = 18'b000000_10_00_10_000_00_0;
    localparam logic [17:0] V_EXI   = 18'b000000_10_01_11_000_00_0;
    localparam logic [17:0] V_AWB   = 18'b000001_00_00_00_000_00_0;
    localparam logic [17:0] V_ADRL  = 18'b000000_10_01_00_000_00_0;
    localparam logic [17:0] V_ADRS  = 18'b000000_10_01_00_001_00_0;
    localparam logic [17:0] V_MRD   = 18'b101000_00_00_00_000_00_0;
    localparam logic [17:0] V_MWB   = 18'b000001_00_00_00_000_01_0;
    localparam logic [17:0] V_MWR   = 18'b111000_00_00_00_000_00_0;
    localparam logic [17:0] V_BRT   = 18'b000010_10_00_01_000_00_0;
    localparam logic [17:0] V_BRN   = 18'b000000_10_00_01_000_00_0;
    localparam logic [17:0] V_JADR  = 18'b000000_10_01_00_000_00_0;
    localparam logic [17:0] V_JMP   = 18'b000010_01_10_00_000_00_0;
    localparam logic [17:0] V_LUI   = 18'b000001_00_00_00_100_11_0;

    localparam logic [6:0] C_R    = 7'b0110011;
    localparam logic [6:0] C_I    = 7'b0010011;
    localparam logic [6:0] C_JALR = 7'b1100111;
    localparam logic [6:0] C_LW   = 7'b0000011;
    localparam logic [6:0] C_SW   = 7'b0100011;
    localparam logic [6:0] C_B    = 7'b1100011;
    localparam logic [6:0] C_LUI  = 7'b0110111;
    localparam logic [6:0] C_JAL  = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        zero;
    logic        neg;
    logic        ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_src;
    logic [17:0] ctl;

    int tests = 0;
    int fails = 0;

    multicycle_controller_if mif ();

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mif.master),
        .opc        (opc),
        .funct3     (funct3),
        .zero       (zero),
        .neg        (neg),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .result_src (result_src),
        .illegal    (illegal)
    );

    assign ctl = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write,
                  reg_write, alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal};

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        mif.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== V_RST) begin
            fails++;
            $display("FAIL reset_hold ctl=%b expected=%b", ctl, V_RST);
        end
        @(negedge clk);
        rst = 1'b0;
        mif.mem_ready = 1'b0;
        #1;
        tests++;
        if (ctl !== V_FET0) begin
            fails++;
            $display("FAIL reset_release ctl=%b expected=%b", ctl, V_FET0);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [17:0] ev [4] = '{V_FET1, V_DEC, V_EXR, V_AWB};
        opc = C_R; funct3 = 3'b000; mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (ctl !== ev[i]) begin
                fails++;
                $display("FAIL add cyc%0d ctl=%b expected=%b", i, ctl, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_addi_fetch_wait();
        logic [17:0] ev [5] = '{V_FET0, V_FET1, V_DEC, V_EXI, V_AWB};
        logic        rdy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opc = C_I; funct3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (ctl !== ev[i]) begin
                fails++;
                $display("FAIL addi cyc%0d ctl=%b expected=%b", i, ctl, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        logic [17:0] ev [7] = '{V_FET1, V_ADRL, V_ADRL, V_MRD, V_MRD, V_MRD, V_MWB};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ev[1] = V_DEC;
        opc = C_LW; funct3 = 3'b010;
        for (int i = 0; i < 7; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (ctl !== ev[i]) begin
                fails++;
                $display("FAIL lw cyc%0d ctl=%b expected=%b", i, ctl, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branches();
        logic [2:0]  f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000};
        logic        z  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        n  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [17:0] eb [6] = '{V_BRT, V_BRN, V_BRN, V_BRT, V_BRN, V_BRN};
        opc = C_B; mif.mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            funct3 = f3[k]; zero = z[k]; neg = n[k];
            for (int i = 0; i < 3; i++) begin
                logic [17:0] e;
                e = (i == 0) ? V_FET1 : (i == 1) ? V_DEC : eb[k];
                #1;
                tests++;
                if (ctl !== e) begin
                    fails++;
                    $display("FAIL branch f3=%b cyc%0d ctl=%b expected=%b", f3[k], i, ctl, e);
                end
                @(negedge clk);
            end
        end
        zero = 1'b0; neg = 1'b0;
    endtask

    task automatic test_jumps_lui();
        logic [17:0] ejr [5] = '{V_FET1, V_DEC, V_JADR, V_JMP, V_AWB};
        logic [17:0] ej  [4] = '{V_FET1, V_DECJ, V_JMP, V_AWB};
        logic [17:0] el  [3] = '{V_FET1, V_DEC, V_LUI};
        mif.mem_ready = 1'b1; funct3 = 3'b000;
        opc = C_JALR;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (ctl !== ejr[i]) begin
                fails++;
                $display("FAIL jalr cyc%0d ctl=%b expected=%b", i, ctl, ejr[i]);
            end
            @(negedge clk);
        end
        opc = C_JAL;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (ctl !== ej[i]) begin
                fails++;
                $display("FAIL jal cyc%0d ctl=%b expected=%b", i, ctl, ej[i]);
            end
            @(negedge clk);
        end
        opc = C_LUI;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctl !== el[i]) begin
                fails++;
                $display("FAIL lui cyc%0d ctl=%b expected=%b", i, ctl, el[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_illegal();
        logic [17:0] es [5] = '{V_FET1, V_DEC, V_ADRS, V_MWR, V_MWR};
        logic        rs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [17:0] ex [3] = '{V_FET1, V_DECX, V_FET0};
        logic        rx [3] = '{1'b1, 1'b1, 1'b0};
        opc = C_SW; funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            mif.mem_ready = rs[i];
            #1;
            tests++;
            if (ctl !== es[i]) begin
                fails++;
                $display("FAIL sw cyc%0d ctl=%b expected=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        opc = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            mif.mem_ready = rx[i];
            #1;
            tests++;
            if (ctl !== ex[i]) begin
                fails++;
                $display("FAIL illegal cyc%0d ctl=%b expected=%b", i, ctl, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [17:0] es [4] = '{V_FET0, V_FET1, V_DEC, V_ADRS};
        logic        rs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        opc = C_SW; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            mif.mem_ready = rs[i];
            #1;
            tests++;
            if (ctl !== es[i]) begin
                fails++;
                $display("FAIL rstwr_pre cyc%0d ctl=%b expected=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        mif.mem_ready = 1'b0;
        #1;
        tests++;
        if (ctl !== V_MWR) begin
            fails++;
            $display("FAIL rstwr_in_wr ctl=%b expected=%b", ctl, V_MWR);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (ctl !== V_RST) begin
            fails++;
            $display("FAIL rstwr_async_drop ctl=%b expected=%b", ctl, V_RST);
        end
        @(negedge clk);
        mif.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctl !== V_RST) begin
            fails++;
            $display("FAIL rstwr_held ctl=%b expected=%b", ctl, V_RST);
        end
        rst = 1'b0;
        opc = C_R;
        #1;
        tests++;
        if (ctl !== V_FET1) begin
            fails++;
            $display("FAIL rstwr_release ctl=%b expected=%b", ctl, V_FET1);
        end
        @(negedge clk);
        #1;
        tests++;
        if (ctl !== V_DEC) begin
            fails++;
            $display("FAIL rstwr_resume ctl=%b expected=%b", ctl, V_DEC);
        end
    endtask

    initial begin
        rst = 1'b1;
        opc = 7'b0; funct3 = 3'b0; zero = 1'b0; neg = 1'b0;
        mif.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_addi_fetch_wait();
        test_lw_wait();
        test_branches();
        test_jumps_lui();
        test_sw_illegal();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
